hazard_pipe_regs: RTL and testbench

//   D/E, E/M and M/W pipeline registers for the hazard-tracking fields, plus the PC/instr tags, of the 5-stage MIPS core.

---
 rtl/hazard_pkg.sv | 36 +++
 rtl/stage_reg.sv | 42 ++++
 rtl/hazard_pipe_regs.sv | 177 +++++++++++++++++
 tb/tb_hazard_pipe_regs.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
//   Shared types for the hazard-tracking pipeline registers of the 5-stage
//   MIPS core.
//   Contents:
//     ADDR_W, TNEW_W, DATA_W  field widths
//     stage_t                 one pipeline stage worth of hazard fields
//     STAGE_BUBBLE            the all-zero stage_t, i.e. a no-op bubble
//     tnew_dec()              saturating Tnew decrement used at E->M
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int ADDR_W = 5;
  localparam int TNEW_W = 3;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] a3;
    logic              we;
    logic [TNEW_W-1:0] tnew;
  } stage_t;

  // A bubble is recognised downstream purely by we == 0 / instr == 0.
  localparam stage_t STAGE_BUBBLE = '0;

  // Tnew counts down by one per stage but never wraps: a producer that is
  // already ready (Tnew == 0) stays ready.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage : hazard_pkg

// File: rtl/stage_reg.sv
// ---------------------------------------------------------------------------
// stage_reg
//   One stage_t pipeline register with asynchronous active-low reset and a
//   synchronous clear that loads a bubble instead of the incoming stage.
//   Ports:
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous active-low reset (register -> all zero)
//     clear_i  in   1 = load STAGE_BUBBLE on this edge instead of d_i
//     d_i      in   incoming stage fields
//     q_o      out  registered stage fields
// ---------------------------------------------------------------------------
module stage_reg
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t stage_q;
  stage_t stage_d;

  always_comb begin
    stage_d = d_i;
    if (clear_i) begin
      stage_d = STAGE_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= STAGE_BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule : stage_reg

// File: rtl/hazard_pipe_regs.sv
// ---------------------------------------------------------------------------
// hazard_pipe_regs
//   D/E, E/M and M/W pipeline registers for the hazard-tracking fields and
//   PC/instruction tags of the 5-stage MIPS core. Supplies the forwarding /
//   stall controller with E, M and W stage addresses, write enables and Tnew,
//   and applies that controller's stall: PC and F/D freeze, D/E takes a bubble.
//   A saturating counter records how many bubbles were inserted.
//   Ports:
//     clk, reset                 clock; asynchronous active-low reset
//     stall                      1 = freeze PC/F-D and bubble D/E this cycle
//     pc_d, instr_d              D-stage PC / instruction
//     a1_d, a2_d, a3_d           D-stage rs, rt, destination addresses
//     we_d, tnew_d               D-stage write enable and Tnew
//     en_pc, en_fd               combinational enables (= ~stall)
//     pc_e/m/w, instr_e/m/w      per-stage PC / instruction tags
//     a1_e a2_e a3_e we_e tnew_e E-stage hazard fields
//     a1_m a2_m a3_m we_m tnew_m M-stage hazard fields
//     a3_w, we_w                 W-stage destination and write enable
//     bubble_cnt                 bubbles inserted since reset (saturating)
// ---------------------------------------------------------------------------
module hazard_pipe_regs
  import hazard_pkg::*;
#(
  parameter int ADDR_W = hazard_pkg::ADDR_W,
  parameter int TNEW_W = hazard_pkg::TNEW_W,
  parameter int DATA_W = hazard_pkg::DATA_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [DATA_W-1:0] pc_d,
  input  logic [DATA_W-1:0] instr_d,
  input  logic [ADDR_W-1:0] a1_d,
  input  logic [ADDR_W-1:0] a2_d,
  input  logic [ADDR_W-1:0] a3_d,
  input  logic              we_d,
  input  logic [TNEW_W-1:0] tnew_d,
  output logic              en_pc,
  output logic              en_fd,
  output logic [DATA_W-1:0] pc_e,
  output logic [DATA_W-1:0] pc_m,
  output logic [DATA_W-1:0] pc_w,
  output logic [DATA_W-1:0] instr_e,
  output logic [DATA_W-1:0] instr_m,
  output logic [DATA_W-1:0] instr_w,
  output logic [ADDR_W-1:0] a1_e,
  output logic [ADDR_W-1:0] a2_e,
  output logic [ADDR_W-1:0] a3_e,
  output logic              we_e,
  output logic [TNEW_W-1:0] tnew_e,
  output logic [ADDR_W-1:0] a1_m,
  output logic [ADDR_W-1:0] a2_m,
  output logic [ADDR_W-1:0] a3_m,
  output logic              we_m,
  output logic [TNEW_W-1:0] tnew_m,
  output logic [ADDR_W-1:0] a3_w,
  output logic              we_w,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int N_STAGES = 3;
  localparam int ST_E     = 0;
  localparam int ST_M     = 1;
  localparam int ST_W     = 2;

  stage_t stage_in  [N_STAGES];
  stage_t stage_out [N_STAGES];
  logic   stage_clr [N_STAGES];

  // -------------------------------------------------------------------------
  // Stage inputs
  // -------------------------------------------------------------------------
  always_comb begin
    stage_in[ST_E]       = STAGE_BUBBLE;
    stage_in[ST_E].pc    = pc_d;
    stage_in[ST_E].instr = instr_d;
    stage_in[ST_E].a1    = a1_d;
    stage_in[ST_E].a2    = a2_d;
    stage_in[ST_E].a3    = a3_d;
    stage_in[ST_E].we    = we_d;
    stage_in[ST_E].tnew  = tnew_d;
  end

  // Everything moves to M untouched except Tnew, which ages by one stage.
  always_comb begin
    stage_in[ST_M]      = stage_out[ST_E];
    stage_in[ST_M].tnew = tnew_dec(stage_out[ST_E].tnew);
  end

  // W only needs the tags plus a3/we; the source addresses and Tnew are
  // dropped so those flops are constant and trim away.
  always_comb begin
    stage_in[ST_W]       = STAGE_BUBBLE;
    stage_in[ST_W].pc    = stage_out[ST_M].pc;
    stage_in[ST_W].instr = stage_out[ST_M].instr;
    stage_in[ST_W].a3    = stage_out[ST_M].a3;
    stage_in[ST_W].we    = stage_out[ST_M].we;
  end

  // -------------------------------------------------------------------------
  // Stage registers: only D/E is ever cleared (by stall); E/M and M/W always
  // advance so older instructions drain past a stall.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
      if (gi == ST_E) begin : g_clr_stall
        assign stage_clr[gi] = stall;
      end else begin : g_clr_none
        assign stage_clr[gi] = 1'b0;
      end

      stage_reg u_stage_reg (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (stage_clr[gi]),
        .d_i     (stage_in[gi]),
        .q_o     (stage_out[gi])
      );
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Bubble counter (saturating)
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (stall && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign en_pc = ~stall;
  assign en_fd = ~stall;

  assign pc_e    = stage_out[ST_E].pc;
  assign instr_e = stage_out[ST_E].instr;
  assign a1_e    = stage_out[ST_E].a1;
  assign a2_e    = stage_out[ST_E].a2;
  assign a3_e    = stage_out[ST_E].a3;
  assign we_e    = stage_out[ST_E].we;
  assign tnew_e  = stage_out[ST_E].tnew;

  assign pc_m    = stage_out[ST_M].pc;
  assign instr_m = stage_out[ST_M].instr;
  assign a1_m    = stage_out[ST_M].a1;
  assign a2_m    = stage_out[ST_M].a2;
  assign a3_m    = stage_out[ST_M].a3;
  assign we_m    = stage_out[ST_M].we;
  assign tnew_m  = stage_out[ST_M].tnew;

  assign pc_w    = stage_out[ST_W].pc;
  assign instr_w = stage_out[ST_W].instr;
  assign a3_w    = stage_out[ST_W].a3;
  assign we_w    = stage_out[ST_W].we;

  assign bubble_cnt = bubble_cnt_q;

  // Fields of the W register that are always zero and have no consumer.
  logic unused_w;
  assign unused_w = ^{stage_out[ST_W].a1, stage_out[ST_W].a2, stage_out[ST_W].tnew};

endmodule : hazard_pipe_regs

// File: tb/tb_hazard_pipe_regs.sv
module tb_hazard_pipe_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] pc_d, instr_d;
  logic [4:0]  a1_d, a2_d, a3_d;
  logic        we_d;
  logic [2:0]  tnew_d;
  logic        en_pc, en_fd;
  logic [31:0] pc_e, pc_m, pc_w, instr_e, instr_m, instr_w;
  logic [4:0]  a1_e, a2_e, a3_e, a1_m, a2_m, a3_m, a3_w;
  logic        we_e, we_m, we_w;
  logic [2:0]  tnew_e, tnew_m;
  logic [31:0] bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  hazard_pipe_regs dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .pc_d       (pc_d),
    .instr_d    (instr_d),
    .a1_d       (a1_d),
    .a2_d       (a2_d),
    .a3_d       (a3_d),
    .we_d       (we_d),
    .tnew_d     (tnew_d),
    .en_pc      (en_pc),
    .en_fd      (en_fd),
    .pc_e       (pc_e),
    .pc_m       (pc_m),
    .pc_w       (pc_w),
    .instr_e    (instr_e),
    .instr_m    (instr_m),
    .instr_w    (instr_w),
    .a1_e       (a1_e),
    .a2_e       (a2_e),
    .a3_e       (a3_e),
    .we_e       (we_e),
    .tnew_e     (tnew_e),
    .a1_m       (a1_m),
    .a2_m       (a2_m),
    .a3_m       (a3_m),
    .we_m       (we_m),
    .tnew_m     (tnew_m),
    .a3_w       (a3_w),
    .we_w       (we_w),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                       input logic we, input logic [2:0] tn, input logic st);
    pc_d = pc; instr_d = ins; a1_d = a1; a2_d = a2; a3_d = a3;
    we_d = we; tnew_d = tn; stall = st;
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d: stall=%0b pc_e=%0h a3_e=%0d we_e=%0b | pc_m=%0h a3_m=%0d tnew_m=%0d | pc_w=%0h a3_w=%0d we_w=%0b | bubbles=%0d",
             cyc, stall, pc_e, a3_e, we_e, pc_m, a3_m, tnew_m, pc_w, a3_w, we_w, bubble_cnt);
  endtask

  initial begin
    // ---------------- 1. reset with random inputs ----------------
    reset = 1'b0;
    drive($urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 3'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      drive($urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 3'($urandom), 1'b1);
    end
    chk("rst_pc_e", pc_e, 0);
    chk("rst_instr_m", instr_m, 0);
    chk("rst_a3_e", a3_e, 0);
    chk("rst_we_e", we_e, 0);
    chk("rst_we_m", we_m, 0);
    chk("rst_we_w", we_w, 0);
    chk("rst_pc_w", pc_w, 0);
    chk("rst_bubble_cnt", bubble_cnt, 0);
    chk("rst_en_pc_stall", en_pc, 0);

    // release between edges, first edge loads D/E
    drive(32'h100, 32'h2002_0001, 5'd0, 5'd0, 5'd2, 1'b1, 3'd1, 1'b0);
    #1 reset = 1'b1;
    chk("en_pc_nostall", en_pc, 1);
    chk("en_fd_nostall", en_fd, 1);
    step();
    chk("rel_pc_e", pc_e, 32'h100);
    chk("rel_a3_e", a3_e, 2);
    chk("rel_cnt", bubble_cnt, 0);

    // ---------------- 2. pass-through ----------------
    drive(32'h200, 32'h1111_1111, 5'd1, 5'd2, 5'd5, 1'b1, 3'd2, 1'b0);
    step();
    chk("pt_a3_e", a3_e, 5);
    chk("pt_tnew_e", tnew_e, 2);
    chk("pt_a1_e", a1_e, 1);
    chk("pt_a2_e", a2_e, 2);
    chk("pt_instr_e", instr_e, 32'h1111_1111);
    drive(32'h204, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0);
    step();
    chk("pt_a3_m", a3_m, 5);
    chk("pt_tnew_m", tnew_m, 1);
    chk("pt_we_m", we_m, 1);
    chk("pt_a1_m", a1_m, 1);
    chk("pt_a2_m", a2_m, 2);
    chk("pt_pc_m", pc_m, 32'h200);
    step();
    chk("pt_a3_w", a3_w, 5);
    chk("pt_we_w", we_w, 1);
    chk("pt_pc_w", pc_w, 32'h200);
    chk("pt_instr_w", instr_w, 32'h1111_1111);

    // ---------------- 4. Tnew saturation ----------------
    drive(32'h300, 32'h0C00_0040, 5'd0, 5'd0, 5'd31, 1'b1, 3'd0, 1'b0);
    step();
    chk("sat_tnew_e", tnew_e, 0);
    drive(32'h304, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd3, 1'b0);
    step();
    chk("sat_tnew_m", tnew_m, 0);
    chk("sat_a3_m", a3_m, 31);
    chk("sat_tnew_e3", tnew_e, 3);
    step();
    chk("dec_tnew_m2", tnew_m, 2);

    // ---------------- 3. single stall ----------------
    drive(32'h400, 32'h8C08_0000, 5'd0, 5'd0, 5'd8, 1'b1, 3'd2, 1'b0);
    step();
    chk("lw_a3_e", a3_e, 8);
    drive(32'h404, 32'h1100_0001, 5'd8, 5'd0, 5'd0, 1'b0, 3'd0, 1'b1);
    #1;
    chk("st_en_pc", en_pc, 0);
    chk("st_en_fd", en_fd, 0);
    step();
    chk("st_we_e", we_e, 0);
    chk("st_a3_e", a3_e, 0);
    chk("st_instr_e", instr_e, 0);
    chk("st_pc_e", pc_e, 0);
    chk("st_lw_a3_m", a3_m, 8);
    chk("st_lw_tnew_m", tnew_m, 1);
    chk("st_cnt", bubble_cnt, 1);
    stall = 1'b0;
    #1;
    chk("st_en_pc_rel", en_pc, 1);
    step();
    chk("beq_instr_e", instr_e, 32'h1100_0001);
    chk("beq_pc_e", pc_e, 32'h404);
    chk("beq_a1_e", a1_e, 8);
    chk("bub_we_m", we_m, 0);
    chk("bub_instr_m", instr_m, 0);
    chk("lw_a3_w", a3_w, 8);
    chk("lw_we_w", we_w, 1);
    chk("st_cnt_hold", bubble_cnt, 1);

    // ---------------- 5. back-to-back stalls ----------------
    drive(32'h500, 32'h5, 5'd1, 5'd1, 5'd9, 1'b1, 3'd1, 1'b0);
    step();
    drive(32'h504, 32'h6, 5'd2, 5'd2, 5'd10, 1'b1, 3'd1, 1'b0);
    step();
    drive(32'h508, 32'h7, 5'd10, 5'd0, 5'd11, 1'b1, 3'd2, 1'b1);
    step();
    chk("b2b1_we_e", we_e, 0);
    chk("b2b1_a3_m", a3_m, 10);
    chk("b2b1_a3_w", a3_w, 9);
    chk("b2b1_we_w", we_w, 1);
    chk("b2b1_cnt", bubble_cnt, 2);
    step();
    chk("b2b2_instr_e", instr_e, 0);
    chk("b2b2_we_m", we_m, 0);
    chk("b2b2_instr_m", instr_m, 0);
    chk("b2b2_a3_w", a3_w, 10);
    chk("b2b2_pc_w", pc_w, 32'h504);
    chk("b2b2_cnt", bubble_cnt, 3);
    stall = 1'b0;
    step();
    chk("b2b_c_pc_e", pc_e, 32'h508);
    chk("b2b_c_tnew_e", tnew_e, 2);
    chk("b2b_cnt_hold", bubble_cnt, 3);

    // ---------------- 6. async reset mid-pipeline ----------------
    drive(32'h50C, 32'h8, 5'd3, 5'd4, 5'd12, 1'b1, 3'd1, 1'b0);
    step();
    drive(32'h510, 32'h9, 5'd5, 5'd6, 5'd13, 1'b1, 3'd2, 1'b0);
    step();
    chk("full_a3_e", a3_e, 13);
    chk("full_a3_m", a3_m, 12);
    chk("full_a3_w", a3_w, 11);
    #2 reset = 1'b0;
    #1;
    chk("ar_pc_e", pc_e, 0);
    chk("ar_a3_e", a3_e, 0);
    chk("ar_a3_m", a3_m, 0);
    chk("ar_we_m", we_m, 0);
    chk("ar_a3_w", a3_w, 0);
    chk("ar_we_w", we_w, 0);
    chk("ar_cnt", bubble_cnt, 0);

    // reset released mid-stall: first edge inserts and counts a bubble
    drive(32'h600, 32'hA, 5'd7, 5'd7, 5'd14, 1'b1, 3'd1, 1'b1);
    step();
    #2 reset = 1'b1;
    step();
    chk("rms_cnt", bubble_cnt, 1);
    chk("rms_we_e", we_e, 0);
    stall = 1'b0;
    step();
    chk("rms_pc_e", pc_e, 32'h600);
    chk("rms_a3_e", a3_e, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_hazard_pipe_regs
